// File: rtl/softmax_loader.sv
// Purpose: collects N signed Q4.12 samples into one packed frame with its running maximum.
// Latency: 1 cycle from the final accepted sample to out_valid; all outputs except in_ready are registered.
// Backpressure: in_ready drops for the whole HOLD phase; en=0 freezes everything. Optional macro: SOFTMAX_LOADER_PAD_EN.
module softmax_loader #(
    parameter int N = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [15:0]                in_data,
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N*16-1:0]            x_flat,
    output logic [15:0]                max_x,
    output logic [$clog2(N+1)-1:0]     out_len
);

    localparam int KW = $clog2(N);
    localparam int LW = $clog2(N+1);

    typedef enum logic {FILL, HOLD} state_t;

    state_t          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic            out_valid_q, out_valid_d;
    logic [N*16-1:0] x_flat_q, x_flat_d;
    logic [15:0]     max_q, max_d;
    logic [LW-1:0]   out_len_q, out_len_d;

    logic in_xfer;
    logic out_xfer;
    logic frame_end;

    assign in_ready  = en && (state_q == FILL) && !rst;
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = en && out_valid_q && out_ready;

`ifdef SOFTMAX_LOADER_PAD_EN
    // A short frame ends early on in_last; a full frame always ends at slot N-1.
    assign frame_end = (k_q == KW'(N-1)) || in_last;
`else
    // Short frames do not exist in this build, so in_last has no effect.
    assign frame_end = (k_q == KW'(N-1));
    logic unused_in_last;
    assign unused_in_last = in_last;
`endif

    // Next-state: slot write, signed running max, frame close and hand-off.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        out_valid_d = out_valid_q;
        x_flat_d    = x_flat_q;
        max_d       = max_q;
        out_len_d   = out_len_q;

        if (in_xfer) begin
            x_flat_d[k_q*16 +: 16] = in_data;
            // First sample seeds the max so stale values from an older frame never leak in.
            if ((k_q == '0) || ($signed(in_data) > $signed(max_q))) begin
                max_d = in_data;
            end
            if (frame_end) begin
                state_d     = HOLD;
                out_valid_d = 1'b1;
                out_len_d   = LW'(k_q) + LW'(1);
                k_d         = '0;
`ifdef SOFTMAX_LOADER_PAD_EN
                // Pad unused slots with the most negative value so they vanish in the softmax.
                for (int i = 0; i < N; i++) begin
                    if (i > int'(k_q)) begin
                        x_flat_d[i*16 +: 16] = 16'h8000;
                    end
                end
`endif
            end else begin
                k_d = k_q + KW'(1);
            end
        end

        if (out_xfer) begin
            state_d     = FILL;
            out_valid_d = 1'b0;
            k_d         = '0;
        end
    end

    // State register: synchronous reset discards any partial or held frame; en=0 freezes all.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FILL;
            k_q         <= '0;
            out_valid_q <= 1'b0;
            x_flat_q    <= '0;
            max_q       <= 16'h0000;
            out_len_q   <= '0;
        end else if (en) begin
            state_q     <= state_d;
            k_q         <= k_d;
            out_valid_q <= out_valid_d;
            x_flat_q    <= x_flat_d;
            max_q       <= max_d;
            out_len_q   <= out_len_d;
        end
    end

    assign out_valid = out_valid_q;
    assign x_flat    = x_flat_q;
    assign max_x     = max_q;
    assign out_len   = out_len_q;

endmodule

// File: tb/tb_softmax_loader.sv
// Purpose: checks softmax_loader (N=8) against a queue-based frame model, directed cases then random traffic.
// Latency: every cycle compares handshake outputs; frame contents are compared whenever a frame is held.
// Backpressure: random out_ready / en / in_valid exercise stalls; resets are injected at random too.
module tb_softmax_loader;

    localparam int N  = 8;
    localparam int W  = N * 16;
    localparam int LW = $clog2(N+1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [15:0]   in_data = 16'h0;
    logic          in_last = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  x_flat;
    logic [15:0]   max_x;
    logic [LW-1:0] out_len;

    int total = 0;
    int bad   = 0;

    // Reference model: samples of the frame in progress, plus the frame being offered downstream.
    logic [15:0] cur[$];
    logic [15:0] frame[N];
    logic [15:0] mmax;
    int          mlen;
    bit          held;
    bit          fresh;

    softmax_loader #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x_flat    (x_flat),
        .max_x     (max_x),
        .out_len   (out_len)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Close the frame: real samples first, remaining slots at -8.0, max over real samples only.
    task automatic close_frame();
        mlen = cur.size();
        mmax = cur[0];
        for (int i = 0; i < N; i++) begin
            frame[i] = (i < mlen) ? cur[i] : 16'h8000;
            if (i < mlen && $signed(cur[i]) > $signed(mmax)) mmax = cur[i];
        end
        held = 1'b1;
        cur.delete();
    endtask

    task automatic model_reset();
        cur.delete();
        for (int i = 0; i < N; i++) frame[i] = 16'h0;
        mmax  = 16'h0;
        mlen  = 0;
        held  = 1'b0;
        fresh = 1'b1;
    endtask

    // One clock cycle: drive, compare at the falling edge, then advance the model past the rising edge.
    task automatic step(input logic v, input logic [15:0] d, input logic l,
                        input logic ordy, input logic e, input logic r);
        logic [W-1:0] exp_flat;
        bit mir;
        in_valid = v; in_data = d; in_last = l; out_ready = ordy; en = e; rst = r;
        @(negedge clk);
        mir = e && !held && !r;
        chk("in_ready", in_ready, mir);
        chk("out_valid", out_valid, held);
        if (held || fresh) begin
            for (int i = 0; i < N; i++) exp_flat[i*16 +: 16] = frame[i];
            chk("x_flat", x_flat, exp_flat);
            chk("max_x", max_x, mmax);
            chk("out_len", out_len, mlen);
        end
        @(posedge clk);
        #1;
        if (r) begin
            model_reset();
        end else if (e && held && ordy) begin
            held = 1'b0;
        end else if (v && mir) begin
            fresh = 1'b0;
            cur.push_back(d);
            if (cur.size() == N) close_frame();
`ifdef SOFTMAX_LOADER_PAD_EN
            else if (l) close_frame();
`endif
        end
    endtask

    task automatic feed(input logic [15:0] d, input logic ordy);
        step(1'b1, d, 1'b0, ordy, 1'b1, 1'b0);
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 16'h0, 1'b0, ordy, 1'b1, 1'b0);
    endtask

    logic [15:0] basic[8] = '{16'h1000, 16'h0800, 16'h2000, 16'hF000, 16'h0000, 16'h1800, 16'h0400, 16'h0C00};
    logic [15:0] negs[8]  = '{16'hE000, 16'hF800, 16'hC000, 16'h8000, 16'hF000, 16'hE800, 16'hD000, 16'hF400};

    initial begin
        model_reset();
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1);

        // Reset mid-fill discards the partial frame; a fresh frame follows.
        for (int i = 0; i < 3; i++) feed(16'h0100 * (i + 1), 1'b0);
        step(1'b1, 16'h7777, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 16'h7777, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) feed(16'h0010 + 16'(i), 1'b0);
        idle(1'b1);

        // Basic frame with immediate consumption.
        for (int i = 0; i < 8; i++) feed(basic[i], 1'b1);
        chk("basic_max", max_x, 16'h2000);
        chk("basic_slot3", x_flat[3*16 +: 16], 16'hF000);
        chk("basic_len", out_len, 8);
        idle(1'b1);

        // All-negative frame: the maximum must come from a signed compare.
        for (int i = 0; i < 8; i++) feed(negs[i], 1'b0);
        chk("neg_max", max_x, 16'hF800);
        idle(1'b1);

        // Downstream backpressure with upstream still offering data.
        for (int i = 0; i < 8; i++) feed(16'($urandom), 1'b0);
        for (int i = 0; i < 5; i++) feed(16'h5555, 1'b0);
        feed(16'h5555, 1'b1);
        feed(16'h1234, 1'b0);
        for (int i = 0; i < 7; i++) feed(16'($urandom), 1'b0);
        idle(1'b1);

        // Enable stall after the 5th accept.
        for (int i = 0; i < 5; i++) feed(16'($urandom), 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 16'h4321, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) feed(16'($urandom), 1'b0);
        chk("stall_done", out_valid, 1'b1);
        idle(1'b1);

        // Short frame marked with in_last on the third sample.
        feed(16'h0400, 1'b0);
        feed(16'h0200, 1'b0);
        step(1'b1, 16'h0100, 1'b1, 1'b0, 1'b1, 1'b0);
`ifdef SOFTMAX_LOADER_PAD_EN
        chk("pad_len", out_len, 3);
        chk("pad_max", max_x, 16'h0400);
        chk("pad_slot7", x_flat[7*16 +: 16], 16'h8000);
`else
        chk("nopad_wait", out_valid, 1'b0);
        for (int i = 0; i < 5; i++) feed(16'($urandom), 1'b0);
        chk("nopad_len", out_len, 8);
`endif
        idle(1'b1);

        // Random traffic with occasional resets.
        for (int c = 0; c < 1500; c++) begin
            step($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 5) == 0,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 9) != 0, $urandom_range(0, 99) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
